calc_keypad: RTL and testbench
==============================

CALC_KEYPAD -- requirements
Module: calc_keypad

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each column stays driven during scanning.
REQ-002 SHALL have parameter DEBOUNCE, default 8: consecutive stable cycles required to accept a press or a release.
REQ-003 SHALL have parameter CMD_HOLD, default 10: cycles a command code is held on cmd.
REQ-004 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port rows, input, 4: keypad row lines, pulled up; low means pressed; asynchronous to clock.
REQ-007 SHALL have port cols, output, 4: column drive, active-low, exactly one bit low at all times.
REQ-008 SHALL have port cmd, output, 4: command to the calculator; 4'b1111 is idle.
REQ-009 SHALL have port key_state, output, 2: FSM state (00 SCAN, 01 DEBOUNCE, 10 EMIT, 11 RELEASE).

Function
REQ-010 SHALL pass rows through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-011 SHALL index keys as code = row*4 + col, where row and col are 0..3 and column c is driven by cols[c]=0.
REQ-012 In SCAN, SHALL drive one column for SCAN_DIV cycles, then advance to the next column; col 3 wraps to col 0.
REQ-013 In SCAN, SHALL sample rs on the last cycle of each column slot; if any bit is low, SHALL capture col and the lowest-index low row, then enter DEBOUNCE with the column held.
REQ-014 In DEBOUNCE, SHALL count cycles while rs[captured row] stays low; after DEBOUNCE consecutive low cycles SHALL enter EMIT.
REQ-015 In DEBOUNCE, SHALL return to SCAN if rs[captured row] goes high, advancing to the next column and clearing the counter.
REQ-016 In EMIT, SHALL drive cmd = captured code for exactly CMD_HOLD cycles, then drive cmd = 4'b1111 and enter RELEASE.
REQ-017 For code 15, SHALL skip EMIT, keep cmd = 4'b1111 and go directly from DEBOUNCE to RELEASE (reserved key).
REQ-018 In RELEASE, SHALL keep the captured column driven and wait for rs[captured row] high for DEBOUNCE consecutive cycles, restarting the count on any low.
REQ-019 On leaving RELEASE, SHALL enter SCAN at the next column.
REQ-020 SHALL produce exactly one command per accepted press; holding a key SHALL NOT repeat it.
REQ-021 SHALL ignore other keys pressed during DEBOUNCE, EMIT or RELEASE; only the captured row and column are monitored.
REQ-022 In any state other than EMIT, cmd SHALL be 4'b1111.
REQ-023 SHALL size all counters to their parameter (at least $clog2(param+1) bits); counters SHALL NOT wrap or overflow within a state.

Reset
REQ-024 While reset is high at a clock edge: key_state=00, cols=4'b1110, cmd=4'b1111, counters=0, synchronizer=4'b1111, capture registers=0.
REQ-025 Reset SHALL take effect from any state, including mid-EMIT; cmd SHALL return to 4'b1111 on the first edge with reset high.
REQ-026 After reset deasserts, scanning SHALL start at col 0 with a full SCAN_DIV slot.

Verification
REQ-027 Idle, with rows=4'b1111 for 40 cycles after reset -> cols rotates 1110,1101,1011,0111,1110 every 4 cycles; cmd stays 1111.
REQ-028 Hold key row0/col1 (rows[0] low while cols[1]=0) for 40 cycles -> cmd=4'd1 for exactly 10 cycles, once; key_state goes 00->01->10->11; no repeat while held.
REQ-029 Hold row2/col2 (code 10, add), release, then after RELEASE hold row0/col3 -> cmd=4'b1010 for 10 cycles, then 4'd3 for 10 cycles, with 1111 in between.
REQ-030 A 3-cycle glitch on rows[1] during DEBOUNCE -> returns to SCAN; cmd stays 1111.
REQ-031 Press row3/col3 (code 15) -> no cmd pulse; key_state goes 01->11.
REQ-032 Assert reset on the 5th cycle of EMIT -> next edge: cmd=1111, cols=1110, key_state=00.

Source files
------------

// File: rtl/calc_keypad.sv
// Scanned 4x4 calculator keypad front end: synchronizes the rows, scans the columns,
// debounces one captured key, emits its code once and waits for the key to be released.
module calc_keypad #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 8,
  parameter int CMD_HOLD = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] cmd,
  output logic [1:0] key_state
);

  localparam int DIV_W  = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(CMD_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CMD_HOLD - 1);

  localparam logic [3:0] CMD_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    S_SCAN     = 2'b00,
    S_DEBOUNCE = 2'b01,
    S_EMIT     = 2'b10,
    S_RELEASE  = 2'b11
  } state_t;

  state_t            state, state_next;
  logic [3:0]        rs_meta, rs;
  logic [1:0]        col_idx, col_next;
  logic [DIV_W-1:0]  div_cnt, div_next;
  logic [DEB_W-1:0]  deb_cnt, deb_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [1:0]        cap_row, cap_row_next;
  logic [1:0]        cap_col, cap_col_next;
  logic [1:0]        low_row;
  logic [3:0]        key_code;

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
    end else begin
      rs_meta <= rows;
      rs      <= rs_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_SCAN;
      col_idx  <= 2'd0;
      div_cnt  <= '0;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      cap_row  <= 2'd0;
      cap_col  <= 2'd0;
    end else begin
      state    <= state_next;
      col_idx  <= col_next;
      div_cnt  <= div_next;
      deb_cnt  <= deb_next;
      hold_cnt <= hold_next;
      cap_row  <= cap_row_next;
      cap_col  <= cap_col_next;
    end
  end

  // Lowest-index pressed row wins when several rows are low in the same slot.
  always_comb begin
    if (!rs[0])      low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
    else             low_row = 2'd3;
  end

  assign key_code = {cap_row, cap_col};

  // NOTE: every next-value is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_next   = state;
    col_next     = col_idx;
    div_next     = div_cnt;
    deb_next     = deb_cnt;
    hold_next    = hold_cnt;
    cap_row_next = cap_row;
    cap_col_next = cap_col;

    unique case (state)
      S_SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_next = '0;
          if (rs != 4'b1111) begin
            state_next   = S_DEBOUNCE;
            cap_row_next = low_row;
            cap_col_next = col_idx;
          end else begin
            col_next = col_idx + 2'd1;
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end

      S_DEBOUNCE: begin
        if (rs[cap_row]) begin
          state_next = S_SCAN;
          col_next   = col_idx + 2'd1;
          deb_next   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_next   = '0;
          // Code 15 is reserved: it is debounced and released but never emitted.
          state_next = (key_code == 4'd15) ? S_RELEASE : S_EMIT;
        end else begin
          deb_next = deb_cnt + DEB_W'(1);
        end
      end

      S_EMIT: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_next  = '0;
          state_next = S_RELEASE;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end

      S_RELEASE: begin
        if (!rs[cap_row]) begin
          deb_next = '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_next   = '0;
          state_next = S_SCAN;
          col_next   = col_idx + 2'd1;
        end else begin
          deb_next = deb_cnt + DEB_W'(1);
        end
      end

      default: state_next = S_SCAN;
    endcase
  end

  // The column index is frozen outside SCAN, so the captured column stays driven.
  always_comb begin
    cols          = 4'b1111;
    cols[col_idx] = 1'b0;
  end

  assign cmd       = (state == S_EMIT) ? key_code : CMD_IDLE;
  assign key_state = state;

endmodule

// File: tb/tb_calc_keypad.sv
// Bench for calc_keypad: a keypad matrix model, a procedural reference model checked every
// cycle, and directed scenarios with literal expectations on command runs and state order.
module tb_calc_keypad;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  localparam int CMD_HOLD = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] cmd;
  logic [1:0] key_state;

  logic [15:0] keys   = '0;
  logic [3:0]  glitch = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  calc_keypad #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE),
    .CMD_HOLD(CMD_HOLD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .cmd      (cmd),
    .key_state(key_state)
  );

  // Matrix: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (glitch[r]) rows[r] = 1'b0;
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       model_go = 1'b0;
  logic       chk_en   = 1'b0;
  logic       stop_cmp = 1'b0;
  logic [3:0] m_cols, m_cmd;
  logic [1:0] m_state;
  logic [3:0] h0, h1, h2;

  // Advance one clock edge; returns the row value the design acts on at that edge
  // (raw rows seen three sample points earlier, through the two-flop synchronizer).
  task automatic adv(output logic [3:0] r);
    @(posedge clock);
    #2;
    r  = h2;
    h2 = h1;
    h1 = h0;
    h0 = rows;
  endtask

  task automatic show_col(input int col);
    m_cols      = 4'b1111;
    m_cols[col] = 1'b0;
  endtask

  initial begin : model
    logic [3:0] r;
    int col, row, code, n;
    logic hit, ok;
    wait (model_go);
    #1;
    h2 = 4'hF; h1 = 4'hF; h0 = rows;
    col = 0; show_col(col); m_cmd = 4'hF; m_state = 2'b00;
    chk_en = 1'b1;
    forever begin
      hit = 1'b0;
      for (int i = 0; i < SCAN_DIV; i++) begin
        adv(r);
        if (i == SCAN_DIV - 1 && r != 4'hF) hit = 1'b1;
      end
      if (!hit) begin
        col = (col + 1) % 4; show_col(col);
      end else begin
        row = 3;
        for (int i = 3; i >= 0; i--) if (!r[i]) row = i;
        m_state = 2'b01;
        ok = 1'b1;
        for (int i = 0; i < DEBOUNCE; i++) begin
          adv(r);
          if (r[row]) begin ok = 1'b0; break; end
        end
        if (!ok) begin
          col = (col + 1) % 4; show_col(col); m_state = 2'b00;
        end else begin
          code = row * 4 + col;
          if (code != 15) begin
            m_state = 2'b10; m_cmd = 4'(code);
            for (int i = 0; i < CMD_HOLD; i++) adv(r);
            m_cmd = 4'hF;
          end
          m_state = 2'b11;
          n = 0;
          while (n < DEBOUNCE) begin
            adv(r);
            n = r[row] ? n + 1 : 0;
          end
          col = (col + 1) % 4; show_col(col); m_state = 2'b00;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && !stop_cmp) begin
      check("cols", 16'(cols), 16'(m_cols));
      check("cmd", 16'(cmd), 16'(m_cmd));
      check("key_state", 16'(key_state), 16'(m_state));
      check("cols_one_low", 16'($countones(~cols)), 16'd1);
    end
  end

  // ---------------- run / state logs ----------------
  int runs[$];
  int st_log[$];
  int cur_val = 0;
  int cur_len = 0;
  logic [1:0] last_st = 2'b00;

  always @(negedge clock) begin
    if (cmd != 4'hF) begin
      if (cur_len > 0 && int'(cmd) != cur_val) begin
        runs.push_back(cur_val * 256 + cur_len);
        cur_len = 0;
      end
      if (cur_len == 0) cur_val = int'(cmd);
      cur_len++;
    end else if (cur_len > 0) begin
      runs.push_back(cur_val * 256 + cur_len);
      cur_len = 0;
    end
    if (key_state != last_st) st_log.push_back(int'(key_state));
    last_st = key_state;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    cycles(1);
    runs.delete();
    st_log.delete();
  endtask

  task automatic press(input int code, input int hold, input int after);
    cycles(1);
    keys[code] = 1'b1;
    cycles(hold);
    keys = '0;
    cycles(after);
  endtask

  // ---------------- directed scenarios ----------------
  logic [3:0] idle_cols [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic seen, got;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b0;
    model_go = 1'b1;

    // Idle rotation straight out of reset.
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i % 4 == 0 && i <= 16) check($sformatf("idle_cols_%0d", i), 16'(cols), 16'(idle_cols[i/4]));
      if (i == 0) begin
        check("reset_cmd", 16'(cmd), 16'hF);
        check("reset_state", 16'(key_state), 16'd0);
      end
    end
    check("idle_runs", 16'(runs.size()), 16'd0);

    // Single press of key 1, held well beyond one command.
    clear_logs();
    press(1, 80, 40);
    check("k1_runs", 16'(runs.size()), 16'd1);
    check("k1_run0", 16'(runs[0]), 16'(1 * 256 + 10));
    check("k1_log_size", 16'(st_log.size()), 16'd4);
    check("k1_log0", 16'(st_log[0]), 16'd1);
    check("k1_log1", 16'(st_log[1]), 16'd2);
    check("k1_log2", 16'(st_log[2]), 16'd3);
    check("k1_log3", 16'(st_log[3]), 16'd0);

    // Add key then key 3.
    clear_logs();
    press(10, 60, 30);
    press(3, 60, 30);
    check("seq_runs", 16'(runs.size()), 16'd2);
    check("seq_run0", 16'(runs[0]), 16'(10 * 256 + 10));
    check("seq_run1", 16'(runs[1]), 16'(3 * 256 + 10));

    // Short glitch on row 1: captured, fails debounce, back to scanning.
    clear_logs();
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      glitch[1] = 1'b1;
      cycles(3);
      glitch[1] = 1'b0;
      cycles(6);
      seen = (st_log.size() > 0);
    end
    cycles(20);
    check("glitch_seen_debounce", 16'(seen), 16'd1);
    check("glitch_log_size", 16'(st_log.size()), 16'd2);
    check("glitch_log0", 16'(st_log[0]), 16'd1);
    check("glitch_log1", 16'(st_log[1]), 16'd0);
    check("glitch_runs", 16'(runs.size()), 16'd0);

    // Reserved key 15: debounce straight into release, no command.
    clear_logs();
    press(15, 60, 30);
    check("k15_runs", 16'(runs.size()), 16'd0);
    check("k15_log_size", 16'(st_log.size()), 16'd3);
    check("k15_log0", 16'(st_log[0]), 16'd1);
    check("k15_log1", 16'(st_log[1]), 16'd3);
    check("k15_log2", 16'(st_log[2]), 16'd0);

    // Reset in the 5th cycle of EMIT for key 5.
    cycles(1);
    keys[5] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (key_state == 2'b10) begin got = 1'b1; break; end
    end
    check("k5_reached_emit", 16'(got), 16'd1);
    repeat (4) @(posedge clock);
    #1;
    stop_cmp = 1'b1;
    reset    = 1'b1;
    keys     = '0;
    @(negedge clock);
    check("k5_cmd_cycle5", 16'(cmd), 16'd5);
    @(negedge clock);
    check("rst_cmd", 16'(cmd), 16'hF);
    check("rst_cols", 16'(cols), 16'hE);
    check("rst_state", 16'(key_state), 16'd0);
    cycles(2);
    reset = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
